// File: rtl/dot4x_phase_sequencer_pkg.sv
// Shared clocking constants and FSM state encoding for the dot4x phase sequencer.
package dot4x_phase_sequencer_pkg;

  localparam int PHASE_BITS     = 5;
  localparam int PHI_RISE_COUNT = 16;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

endpackage

// File: rtl/dot4x_phase_sequencer_sync2.sv
// Two-flop synchronizer bringing the asynchronous MMCM lock flag into the dot4x domain.
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dot4x_phase_sequencer.sv
// Lock-qualified reset release and dot/phi sub-phase generation in the dot4x domain.
// Optional saturating lock-loss counter enabled by defining LOCK_LOSS_COUNTER_EN.
module dot4x_phase_sequencer
  import dot4x_phase_sequencer_pkg::*;
#(
  parameter int LOCK_WAIT = 1024
) (
  input  logic       clk_dot4x,
  input  logic       reset_n,
  input  logic       locked,
  output logic       sys_rst,
  output logic [3:0] dot_phase,
  output logic       clk_phi,
  output logic       phi_rise,
  output logic [7:0] lock_loss_count
);

  seq_state_t            state;
  logic                  lock_s;
  logic [15:0]           wait_cnt;
  logic [PHASE_BITS-1:0] phase_cnt;
  logic [PHASE_BITS-1:0] phase_next;

  sync2 u_lock_sync (
    .clk     (clk_dot4x),
    .reset_n (reset_n),
    .d       (locked),
    .q       (lock_s)
  );

  assign phase_next = phase_cnt + PHASE_BITS'(1);

  // Outputs are registered together with the state so they always describe the current state.
  always_ff @(posedge clk_dot4x or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_LOCK;
      wait_cnt  <= 16'd0;
      phase_cnt <= '0;
      sys_rst   <= 1'b1;
      dot_phase <= 4'b0000;
      clk_phi   <= 1'b0;
      phi_rise  <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          wait_cnt  <= 16'd0;
          phase_cnt <= '0;
          if (lock_s) state <= SETTLE;
        end
        SETTLE: begin
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            wait_cnt <= 16'd0;
          end else if (wait_cnt == 16'(LOCK_WAIT - 1)) begin
            state     <= RUN;
            wait_cnt  <= 16'd0;
            phase_cnt <= '0;
            sys_rst   <= 1'b0;
            dot_phase <= 4'b0001;
            clk_phi   <= 1'b0;
            phi_rise  <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            // Abandon any partial phi period; the next RUN starts cleanly at phase 0.
            state     <= WAIT_LOCK;
            phase_cnt <= '0;
            sys_rst   <= 1'b1;
            dot_phase <= 4'b0000;
            clk_phi   <= 1'b0;
            phi_rise  <= 1'b0;
          end else begin
            phase_cnt <= phase_next;
            dot_phase <= 4'b0001 << phase_next[1:0];
            clk_phi   <= phase_next[PHASE_BITS-1];
            phi_rise  <= (phase_next == PHASE_BITS'(PHI_RISE_COUNT));
          end
        end
        default: begin
          state     <= WAIT_LOCK;
          wait_cnt  <= 16'd0;
          phase_cnt <= '0;
          sys_rst   <= 1'b1;
          dot_phase <= 4'b0000;
          clk_phi   <= 1'b0;
          phi_rise  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOCK_LOSS_COUNTER_EN
  logic [7:0] loss_cnt;

  always_ff @(posedge clk_dot4x or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt <= 8'd0;
    end else if (state == RUN && !lock_s && loss_cnt != 8'hFF) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign lock_loss_count = loss_cnt;
`else
  assign lock_loss_count = 8'd0;
`endif

endmodule

// File: doc/dot4x_phase_sequencer.md
DOT4X_PHASE_SEQUENCER -- requirements
Module: dot4x_phase_sequencer

Interface
REQ-001 SHALL have parameter LOCK_WAIT, default 1024: consecutive synchronized-locked cycles required before release; legal range 2..65535.
REQ-002 SHALL have port clk_dot4x  input  1  sole clock (dot4x domain).
REQ-003 SHALL have port reset_n  input  1  asynchronous assert, active-low reset.
REQ-004 SHALL have port locked  input  1  MMCM lock status, asynchronous to clk_dot4x.
REQ-005 SHALL have port sys_rst  output  1  active-high core reset.
REQ-006 SHALL have port dot_phase  output  4  one-hot dot-clock sub-phase enable.
REQ-007 SHALL have port clk_phi  output  1  phi level, 32 dot4x cycles per period.
REQ-008 SHALL have port phi_rise  output  1  single-cycle pulse on the cycle clk_phi goes 0->1.
REQ-009 SHALL have port lock_loss_count  output  8  saturating count of lock-loss events.

Function
REQ-010 SHALL synchronize locked through 2 flops (lock_s); no other logic SHALL use raw locked.
REQ-011 SHALL implement FSM states WAIT_LOCK, SETTLE, RUN.
REQ-012 WAIT_LOCK: wait counter = 0; lock_s=1 -> SETTLE.
REQ-013 SETTLE: wait counter +1 per cycle while lock_s=1; lock_s=0 -> WAIT_LOCK with counter cleared; counter = LOCK_WAIT-1 with lock_s=1 -> RUN.
REQ-014 RUN: lock_s=0 -> WAIT_LOCK in the next cycle, regardless of phase counter value.
REQ-015 sys_rst SHALL be registered; 1 in every cycle the FSM is not RUN, 0 from the first RUN cycle.
REQ-016 5-bit phase counter SHALL be 0 outside RUN; +1 each RUN cycle; wraps 31->0.
REQ-017 dot_phase SHALL be 4'b0001 << counter[1:0] in RUN, 4'b0000 otherwise.
REQ-018 clk_phi SHALL equal counter[4] in RUN, 0 otherwise.
REQ-019 phi_rise SHALL be 1 exactly when RUN and counter = 16.
REQ-020 First RUN cycle SHALL show counter 0, dot_phase 4'b0001, clk_phi 0, sys_rst 0.
REQ-021 Lock loss mid-phi SHALL force counter to 0 and all phase outputs to 0 on entering WAIT_LOCK; no partial phi resumes.
REQ-022 All outputs SHALL be decoded only from registered state; no combinational path from locked.

Reset
REQ-023 reset_n=0 SHALL asynchronously force: sync flops 0, FSM WAIT_LOCK, counters 0, sys_rst 1, dot_phase 0, clk_phi 0, phi_rise 0, lock_loss_count 0.
REQ-024 Deassertion SHALL be used as-is; the reset-release synchronizer lives at top level.

Configuration
REQ-025 Macro LOCK_LOSS_COUNTER_EN defined: lock_loss_count increments by 1 on each RUN->WAIT_LOCK transition and saturates at 255.
REQ-026 Without LOCK_LOSS_COUNTER_EN: lock_loss_count tied 8'd0 and no counter register inferred.

Structure
REQ-027 State encoding and the PHI_RISE_COUNT (16) and PHASE_BITS (5) constants SHALL live in the shared clocking package.
REQ-028 The 2-flop locked synchronizer SHALL be a sub-module named sync2.

Verification
REQ-029 reset_n low, locked=1, release reset -> sys_rst=1 for 2 sync cycles + 1024 SETTLE cycles, then 0; first RUN dot_phase=4'b0001.
REQ-030 In RUN for 64 cycles -> dot_phase cycles 0001,0010,0100,1000; clk_phi 16 low/16 high; phi_rise at counter 16 only, twice.
REQ-031 locked drops at SETTLE count 500 -> back to WAIT_LOCK; relock needs a full 1024 cycles; sys_rst stays 1 throughout.
REQ-032 locked drops at counter 20 in RUN -> after sync latency sys_rst=1, clk_phi=0, dot_phase=0; lock_loss_count=1 (macro on) or 0 (macro off).
REQ-033 300 lock-loss events with macro on -> lock_loss_count saturates at 255.
REQ-034 reset_n asserted mid-RUN -> all outputs reach reset values with no clk_dot4x edge.
